// File: rtl/matmul_pkg.sv
// Shared constants and types for the complex matrix-multiply datapath.
package matmul_pkg;

  // Default width of the accumulator results (signed Q20.11).
  localparam int ANCHOPALABRA = 32;

  // Number of fractional bits in the Q20.11 accumulator format.
  localparam int ACC_FRAC = 11;

  // Result collector phases: gather a full matrix, then stream it out.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/result_collector_if.sv
// Row-major result stream: valid/ready handshake with data and row/col tags.
interface result_collector_if #(
  parameter int W    = matmul_pkg::ANCHOPALABRA,
  parameter int RC_W = 2
);
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_real;
  logic [W-1:0]    out_imag;
  logic [RC_W-1:0] out_row;
  logic [RC_W-1:0] out_col;
  logic            out_last;

  modport master (
    output out_valid, out_real, out_imag, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_real, out_imag, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/result_collector_buf.sv
// Element store for one result matrix: synchronous write, combinational read.
module result_buf #(
  parameter int W     = 64,
  parameter int DEPTH = 9,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [W-1:0]     rdata_o
);
  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(DEPTH - 1);

  // Contents are deliberately not reset; a matrix is always rewritten before it is read.
  logic [W-1:0] mem_q [DEPTH];

  // Write port: store one element when enabled and the address is in range.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i <= LAST_ADDR)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: out-of-range addresses return zero instead of undefined data.
  always_comb begin
    rdata_o = '0;
    if (raddr_i <= LAST_ADDR) begin
      rdata_o = mem_q[raddr_i];
    end else begin
      rdata_o = '0;
    end
  end
endmodule

// File: rtl/result_collector.sv
// Buffers one DIM x DIM complex result matrix from the accumulators and
// streams it out row-major with row/col tags over a valid/ready interface.
module result_collector #(
  parameter int ANCHOPALABRA = matmul_pkg::ANCHOPALABRA,
  parameter int DIM          = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    flag_r,
  input  logic                    flag_i,
  input  logic [ANCHOPALABRA-1:0] acc_r,
  input  logic [ANCHOPALABRA-1:0] acc_i,
  result_collector_if.master      out_if,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  import matmul_pkg::*;

  localparam int N     = DIM * DIM;
  localparam int IDX_W = clog2_min1(N);
  localparam int RC_W  = clog2_min1(DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [RC_W-1:0]  COL_LAST = RC_W'(DIM - 1);
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic [RC_W-1:0]  RC_ZERO  = RC_W'(0);

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]            rd_idx_q, rd_idx_d;
  logic [RC_W-1:0]             row_q, row_d;
  logic [RC_W-1:0]             col_q, col_d;
  logic                        flag_q;
  logic                        err_q, err_d;
  logic                        done_q, done_d;
  logic                        we_s;
  logic                        capture_s;
  logic                        valid_s;
  logic                        handshake_s;
  logic                        last_s;
  logic [2*ANCHOPALABRA-1:0]   rdata_s;

  // A flag held high for several cycles is one event; ena gates capture only.
  assign capture_s   = ena && flag_r && !flag_q;
  assign valid_s     = (state_q == DRAIN);
  assign handshake_s = valid_s && out_if.out_ready;
  assign last_s      = (rd_idx_q == LAST_IDX);

  result_buf #(
    .W    (2 * ANCHOPALABRA),
    .DEPTH(N),
    .IDX_W(IDX_W)
  ) u_buf (
    .clk    (clk),
    .we_i   (we_s),
    .waddr_i(wr_idx_q),
    .wdata_i({acc_r, acc_i}),
    .raddr_i(rd_idx_q),
    .rdata_o(rdata_s)
  );

  // Next-state logic: fill the buffer in COLLECT, walk it row-major in DRAIN.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    row_d    = row_q;
    col_d    = col_q;
    we_s     = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    if (flag_i != flag_r) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      COLLECT: begin
        if (capture_s) begin
          we_s = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = IDX_ZERO;
            rd_idx_d = IDX_ZERO;
            row_d    = RC_ZERO;
            col_d    = RC_ZERO;
            state_d  = DRAIN;
          end else begin
            wr_idx_d = wr_idx_q + IDX_ONE;
          end
        end else begin
          wr_idx_d = wr_idx_q;
        end
      end
      DRAIN: begin
        // Captures while draining are dropped; they only flag an overrun.
        if (capture_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
        if (handshake_s) begin
          rd_idx_d = rd_idx_q + IDX_ONE;
          if (col_q == COL_LAST) begin
            col_d = RC_ZERO;
            row_d = row_q + RC_ONE;
          end else begin
            col_d = col_q + RC_ONE;
          end
          if (last_s) begin
            state_d = COLLECT;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          rd_idx_d = rd_idx_q;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State, counters, flag history and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      wr_idx_q <= IDX_ZERO;
      rd_idx_q <= IDX_ZERO;
      row_q    <= RC_ZERO;
      col_q    <= RC_ZERO;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      flag_q   <= flag_r;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Data and tags are forced to zero whenever no element is offered.
  assign out_if.out_valid = valid_s;
  assign out_if.out_real  = valid_s ? rdata_s[2*ANCHOPALABRA-1:ANCHOPALABRA] : '0;
  assign out_if.out_imag  = valid_s ? rdata_s[ANCHOPALABRA-1:0] : '0;
  assign out_if.out_row   = valid_s ? row_q : RC_ZERO;
  assign out_if.out_col   = valid_s ? col_q : RC_ZERO;
  assign out_if.out_last  = valid_s && last_s;
  assign busy             = valid_s;
  assign done             = done_q;
  assign err              = err_q;
endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector (DIM=3): directed table, corner sequences and
// random traffic, all checked against a matrix-level reference model.
module tb_result_collector;
  localparam int W    = 32;
  localparam int DIM  = 3;
  localparam int N    = DIM * DIM;
  localparam int RC_W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b0;
  logic         flag_r = 1'b0;
  logic         flag_i = 1'b0;
  logic [W-1:0] acc_r = '0;
  logic [W-1:0] acc_i = '0;
  logic         busy, done, err;

  result_collector_if #(.W(W), .RC_W(RC_W)) bus ();

  result_collector #(.ANCHOPALABRA(W), .DIM(DIM)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .flag_r(flag_r),
    .flag_i(flag_i),
    .acc_r (acc_r),
    .acc_i (acc_i),
    .out_if(bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;

  // Reference model: a list of captured elements plus a beat pointer.
  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } elem_t;
  elem_t m_mat[$];
  bit    m_drain, m_err, m_done, m_prev;
  int    m_beat;

  typedef struct packed {
    bit           fr, fi, rdy;
    logic [W-1:0] ar, ai;
    bit           e_valid, e_last, e_done;
    logic [W-1:0] e_re, e_im;
    logic [1:0]   e_row, e_col;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mat.delete();
    m_drain = 1'b0;
    m_err   = 1'b0;
    m_done  = 1'b0;
    m_prev  = 1'b0;
    m_beat  = 0;
  endtask

  task automatic model_edge(input bit fr, input bit fi, input bit en, input bit rdy,
                            input logic [W-1:0] ar, input logic [W-1:0] ai);
    bit ev;
    ev = en && fr && !m_prev;
    m_done = 1'b0;
    if (fi != fr) m_err = 1'b1;
    if (m_drain) begin
      if (ev) m_err = 1'b1;
      if (rdy) begin
        m_beat++;
        if (m_beat == N) begin
          m_done  = 1'b1;
          m_drain = 1'b0;
          m_beat  = 0;
          m_mat.delete();
        end
      end
    end else if (ev) begin
      m_mat.push_back({ar, ai});
      if (m_mat.size() == N) begin
        m_drain = 1'b1;
        m_beat  = 0;
      end
    end
    m_prev = fr;
  endtask

  task automatic check_outputs();
    logic [W-1:0] e_re, e_im;
    int e_row, e_col;
    e_re = '0; e_im = '0; e_row = 0; e_col = 0;
    if (m_drain) begin
      e_re  = m_mat[m_beat].re;
      e_im  = m_mat[m_beat].im;
      e_row = m_beat / DIM;
      e_col = m_beat % DIM;
    end
    chk("valid", bus.out_valid, m_drain);
    chk("real",  bus.out_real, e_re);
    chk("imag",  bus.out_imag, e_im);
    chk("row",   bus.out_row, e_row);
    chk("col",   bus.out_col, e_col);
    chk("last",  bus.out_last, m_drain && (m_beat == N - 1));
    chk("busy",  busy, m_drain);
    chk("done",  done, m_done);
    chk("err",   err, m_err);
  endtask

  // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit fr, input bit fi, input bit en, input bit rdy,
                       input logic [W-1:0] ar, input logic [W-1:0] ai);
    flag_r = fr; flag_i = fi; ena = en; bus.out_ready = rdy; acc_r = ar; acc_i = ai;
    if (bus.out_valid && rdy) beats++;
    model_edge(fr, fi, en, rdy, ar, ai);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic pulse(input bit fi, input bit en, input bit rdy,
                       input logic [W-1:0] ar, input logic [W-1:0] ai);
    cycle(1'b1, fi, en, rdy, ar, ai);
    cycle(1'b0, 1'b0, en, rdy, '0, '0);
  endtask

  task automatic case1_pulses(input bit rdy);
    logic [W-1:0] v;
    for (int k = 1; k <= N; k++) begin
      v = 32'(k) * 32'h800;
      pulse(1'b1, 1'b1, rdy, v, 32'h0 - v);
    end
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (!m_drain) break;
      cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
    end
    chk("drain_end_valid", bus.out_valid, 1'b0);
  endtask

  // Asynchronous reset raised mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    rst = 1'b1; flag_r = 1'b0; flag_i = 1'b0; ena = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_err",   err, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_real",  bus.out_real, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [W-1:0] x;
    int pat[5];
    pat = '{0, 0, 1, 0, 1};

    // Directed table for the basic 9-element matrix.
    for (int k = 1; k <= N; k++) begin
      v = '0;
      v.fr = 1'b1; v.fi = 1'b1; v.rdy = 1'b1;
      v.ar = 32'(k) * 32'h800;
      v.ai = 32'h0 - v.ar;
      if (k == N) begin
        v.e_valid = 1'b1;
        v.e_re = 32'h800;
        v.e_im = 32'h0 - 32'h800;
      end
      tbl.push_back(v);
      if (k != N) begin
        v = '0;
        v.rdy = 1'b1;
        tbl.push_back(v);
      end
    end
    for (int j = 1; j < N; j++) begin
      v = '0;
      v.rdy = 1'b1;
      v.e_valid = 1'b1;
      v.e_re = 32'(j + 1) * 32'h800;
      v.e_im = 32'h0 - v.e_re;
      v.e_row = 2'(j / DIM);
      v.e_col = 2'(j % DIM);
      v.e_last = (j == N - 1);
      tbl.push_back(v);
    end
    v = '0; v.rdy = 1'b1; v.e_done = 1'b1;
    tbl.push_back(v);
    v = '0; v.rdy = 1'b1;
    tbl.push_back(v);

    // Power-on reset state.
    bus.out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Case 1: basic matrix through the table.
    foreach (tbl[i]) begin
      cycle(tbl[i].fr, tbl[i].fi, 1'b1, tbl[i].rdy, tbl[i].ar, tbl[i].ai);
      chk("t_valid", bus.out_valid, tbl[i].e_valid);
      chk("t_real",  bus.out_real, tbl[i].e_re);
      chk("t_imag",  bus.out_imag, tbl[i].e_im);
      chk("t_row",   bus.out_row, tbl[i].e_row);
      chk("t_col",   bus.out_col, tbl[i].e_col);
      chk("t_last",  bus.out_last, tbl[i].e_last);
      chk("t_done",  done, tbl[i].e_done);
      chk("t_busy",  busy, tbl[i].e_valid);
    end

    // Case 2: backpressure with a repeating 0,0,1,0,1 ready pattern.
    do_reset();
    for (int k = 0; k < N; k++) pulse(1'b1, 1'b1, 1'b0, $urandom, $urandom);
    beats = 0;
    for (int c = 0; c < 60; c++) begin
      if (!m_drain) break;
      cycle(1'b0, 1'b0, 1'b1, pat[c % 5] != 0, '0, '0);
    end
    chk("bp_beats", beats, N);
    chk("bp_end_valid", bus.out_valid, 1'b0);

    // Case 3: held flag counts once, ena=0 pulse is ignored.
    do_reset();
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h111, 32'h222);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    pulse(1'b1, 1'b0, 1'b0, 32'hBAD, 32'hBAD);
    for (int k = 0; k < N - 2; k++) pulse(1'b1, 1'b1, 1'b0, $urandom, $urandom);
    chk("ena_not_yet_valid", bus.out_valid, 1'b0);
    pulse(1'b1, 1'b1, 1'b0, 32'h999, 32'h888);
    chk("ena_now_valid", bus.out_valid, 1'b1);
    chk("ena_first_real", bus.out_real, 32'h111);
    drain(20);

    // Case 4: capture attempt during DRAIN is dropped and flags an error.
    do_reset();
    case1_pulses(1'b0);
    pulse(1'b1, 1'b1, 1'b0, 32'hDEAD, 32'hDEAD);
    chk("overrun_err", err, 1'b1);
    chk("overrun_first", bus.out_real, 32'h800);
    drain(20);

    // Case 5: flag_i disagreeing with flag_r still captures but sets err.
    do_reset();
    for (int k = 1; k <= N; k++) begin
      x = 32'(k) * 32'h800;
      pulse(k != 3, 1'b1, 1'b0, x, 32'h0 - x);
    end
    chk("mismatch_err", err, 1'b1);
    chk("mismatch_valid", bus.out_valid, 1'b1);
    beats = 0;
    drain(20);
    chk("mismatch_beats", beats, N);

    // Case 6: reset after 5 captures and again mid-drain.
    do_reset();
    for (int k = 0; k < 5; k++) pulse(1'b1, 1'b1, 1'b0, $urandom, $urandom);
    do_reset();
    for (int k = 0; k < N; k++) pulse(1'b1, 1'b1, 1'b0, $urandom, $urandom);
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
    chk("mid_drain_row", bus.out_row, 2'd1);
    do_reset();
    case1_pulses(1'b0);
    chk("fresh_row", bus.out_row, 2'd0);
    chk("fresh_col", bus.out_col, 2'd0);
    chk("fresh_err", err, 1'b0);
    drain(20);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      bit fr, fi;
      fr = ($urandom_range(0, 2) == 0);
      fi = ($urandom_range(0, 39) == 0) ? !fr : fr;
      cycle(fr, fi, $urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
